arf_frame_driver: RTL and testbench

- Sequential front/back end for the arf_variance combinational datapath.
- Gathers 8 serial 16-bit samples from a valid/ready stream into one parallel frame and presents it on the datapath inputs (in_1_0..in_8_0).
- Waits a programmable settle time, then captures both 64-bit results (out_27, out_28) and returns them as a 2-beat valid/ready output stream.
- Sits between the sample source and the datapath instance.

---
 rtl/arf_pkg.sv | 25 ++
 rtl/arf_result_emitter.sv | 78 +++++++
 rtl/arf_frame_driver.sv | 99 +++++++++
 tb/tb_arf_frame_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// arf_pkg: shared constants and types for the arf_variance frame driver.
// Optional feature macro used by this block: ARF_FRAME_DRIVER_CHECKSUM_EN.
package arf_pkg;

    localparam int ARF_N_IN  = 8;
    localparam int ARF_IN_W  = 16;
    localparam int ARF_OUT_W = 64;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        EMIT    = 2'd2
    } arf_state_t;

    typedef logic [15:0] arf_sample_t;
    typedef logic [63:0] arf_result_t;

    // Index of the final result beat of a frame.
`ifdef ARF_FRAME_DRIVER_CHECKSUM_EN
    localparam logic [1:0] ARF_LAST_BEAT = 2'd2;
`else
    localparam logic [1:0] ARF_LAST_BEAT = 2'd1;
`endif

endpackage

// File: rtl/arf_result_emitter.sv
// arf_result_emitter: captures the datapath results and streams them out as
// a short valid/ready burst (res_a, res_b and, with
// ARF_FRAME_DRIVER_CHECKSUM_EN defined, a checksum beat).
module arf_result_emitter
    import arf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  arf_result_t res_a,
    input  arf_result_t res_b,
    input  logic        m_ready,
    output logic        m_valid,
    output arf_result_t m_data,
    output logic        m_last,
    output logic        done
);

    arf_result_t cap_a;
    arf_result_t cap_b;
    logic [1:0]  beat;
    arf_result_t next_data;

`ifdef ARF_FRAME_DRIVER_CHECKSUM_EN
    logic [15:0] frame_count;

    // Completed-frame counter folded into the checksum beat; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            frame_count <= '0;
        else if (done)
            frame_count <= frame_count + 16'd1;
    end
`endif

    // Final beat handed over to the sink ends the frame.
    assign done = m_valid & m_ready & m_last;

    // Data for the beat following the current one.
    always_comb begin
        next_data = cap_b;
`ifdef ARF_FRAME_DRIVER_CHECKSUM_EN
        if (beat == 2'd1)
            next_data = cap_a ^ cap_b ^ {48'b0, frame_count};
`endif
    end

    // Capture results, then advance one beat per accepted transfer; beats
    // stay registered and stable while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_a   <= '0;
            cap_b   <= '0;
            beat    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (capture) begin
            cap_a   <= res_a;
            cap_b   <= res_b;
            beat    <= '0;
            m_valid <= 1'b1;
            m_data  <= res_a;
            m_last  <= 1'b0;
        end else if (m_valid && m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                beat    <= '0;
            end else begin
                beat    <= beat + 2'd1;
                m_data  <= next_data;
                m_last  <= ((beat + 2'd1) == ARF_LAST_BEAT);
            end
        end
    end

endmodule

// File: rtl/arf_frame_driver.sv
// arf_frame_driver: gathers N_IN serial samples into a parallel frame for the
// arf_variance datapath, waits SETTLE cycles, then streams the results out.
// Optional feature macro: ARF_FRAME_DRIVER_CHECKSUM_EN (adds a checksum beat).
module arf_frame_driver
    import arf_pkg::*;
#(
    parameter int N_IN   = ARF_N_IN,
    parameter int IN_W   = ARF_IN_W,
    parameter int OUT_W  = ARF_OUT_W,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_W-1:0]      s_data,
    output logic [N_IN*IN_W-1:0] frame_data,
    output logic                 frame_valid,
    input  logic [OUT_W-1:0]     res_a,
    input  logic [OUT_W-1:0]     res_b,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_W-1:0]     m_data,
    output logic                 m_last
);

    localparam int          IDX_W    = $clog2(N_IN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [3:0]  SETTLE_L = 4'(SETTLE);

    arf_state_t                    state;
    logic [IDX_W-1:0]              idx;
    logic [N_IN-1:0][IN_W-1:0]     slots;
    logic [3:0]                    cnt;
    logic                          capture;
    logic                          done;

    assign frame_data = slots;

    // Results are sampled on the WAIT cycle whose settle count has run out.
    assign capture = (state == WAIT) && (cnt == 4'd0);

    // Collection and settle-timing FSM; one frame in flight at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            idx         <= '0;
            slots       <= '0;
            frame_valid <= 1'b0;
            s_ready     <= 1'b1;
            cnt         <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (s_valid && s_ready) begin
                        slots[idx] <= s_data;
                        if (idx == IDX_LAST) begin
                            idx         <= '0;
                            frame_valid <= 1'b1;
                            s_ready     <= 1'b0;
                            cnt         <= SETTLE_L;
                            state       <= WAIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= EMIT;
                    else
                        cnt <= cnt - 4'd1;
                end
                EMIT: begin
                    if (done) begin
                        frame_valid <= 1'b0;
                        s_ready     <= 1'b1;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    arf_result_emitter u_emit (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .res_a   (res_a),
        .res_b   (res_b),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (done)
    );

endmodule

// File: tb/tb_arf_frame_driver.sv
// tb_arf_frame_driver: directed bench for arf_frame_driver with a stub
// datapath (res_a = sum of samples, res_b = low 64 frame bits). A second
// instance runs with SETTLE=0. Honors ARF_FRAME_DRIVER_CHECKSUM_EN.
module tb_arf_frame_driver;

`ifdef ARF_FRAME_DRIVER_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic dv = 1'b0, dr = 1'b0;
    logic [15:0] dd = '0;
    int sel = 0;

    // instance with SETTLE=2
    logic s_valid, s_ready, frame_valid, m_valid, m_ready, m_last;
    logic [127:0] frame_data;
    logic [63:0] res_a, res_b, m_data;
    // instance with SETTLE=0
    logic s_valid0, s_ready0, frame_valid0, m_valid0, m_ready0, m_last0;
    logic [127:0] frame_data0;
    logic [63:0] res_a0, res_b0, m_data0;

    assign s_valid  = dv & (sel == 0);
    assign s_valid0 = dv & (sel == 1);
    assign m_ready  = dr & (sel == 0);
    assign m_ready0 = dr & (sel == 1);

    logic o_s_ready, o_frame_valid, o_m_valid, o_m_last;
    logic [127:0] o_frame_data;
    logic [63:0] o_m_data;
    assign o_s_ready     = sel ? s_ready0     : s_ready;
    assign o_frame_valid = sel ? frame_valid0 : frame_valid;
    assign o_m_valid     = sel ? m_valid0     : m_valid;
    assign o_m_last      = sel ? m_last0      : m_last;
    assign o_frame_data  = sel ? frame_data0  : frame_data;
    assign o_m_data      = sel ? m_data0      : m_data;

    // stub datapath
    always_comb begin
        res_a  = '0;
        res_a0 = '0;
        for (int k = 0; k < 8; k++) begin
            res_a  = res_a  + 64'(frame_data[k*16 +: 16]);
            res_a0 = res_a0 + 64'(frame_data0[k*16 +: 16]);
        end
        res_b  = frame_data[63:0];
        res_b0 = frame_data0[63:0];
    end

    arf_frame_driver #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(dd),
        .frame_data(frame_data), .frame_valid(frame_valid), .res_a(res_a), .res_b(res_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

    arf_frame_driver #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(dd),
        .frame_data(frame_data0), .frame_valid(frame_valid0), .res_a(res_a0), .res_b(res_b0),
        .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .m_last(m_last0));

    int checks = 0, errors = 0;
    logic [15:0] smp [8];
    int fcs [2];

    function automatic logic [63:0] f_sum();
        logic [63:0] s = '0;
        for (int k = 0; k < 8; k++) s = s + 64'(smp[k]);
        return s;
    endfunction

    function automatic logic [127:0] f_frame();
        logic [127:0] f = '0;
        for (int k = 0; k < 8; k++) f[k*16 +: 16] = smp[k];
        return f;
    endfunction

    task automatic send_samples(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            dv = 1'b1;
            dd = smp[i];
            while (!o_s_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL s_ready_timeout: sample %0d never accepted", i);
            end
            @(negedge clk);
            if (gap != 0 && i < n - 1) begin
                dv = 1'b0;
                @(negedge clk);
            end
        end
        dv = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [127:0] exp);
        checks++;
        if (o_frame_data !== exp || o_frame_valid !== 1'b1 || o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: frame=%h fv=%b s_ready=%b, need frame=%h fv=1 s_ready=0",
                     name, o_frame_data, o_frame_valid, o_s_ready, exp);
        end
    endtask

    task automatic expect_latency(input string name, input int exp);
        int c = 0;
        while (!o_m_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c !== exp) begin
            errors++;
            $display("FAIL %s: m_valid after %0d cycles, need %0d", name, c, exp);
        end
    endtask

    task automatic recv_beats(input string name, input int stall,
                              input logic [63:0] ea, input logic [63:0] eb);
        logic [63:0] e [3];
        e[0] = ea;
        e[1] = eb;
        e[2] = ea ^ eb ^ {48'b0, 16'(fcs[sel])};
        for (int b = 0; b < NB; b++) begin
            dr = 1'b0;
            for (int s = 0; s < stall; s++) begin
                checks++;
                if (o_m_valid !== 1'b1 || o_m_data !== e[b] || o_m_last !== (b == NB - 1) ||
                    o_s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_stall beat%0d: v=%b d=%h l=%b sr=%b, need v=1 d=%h l=%b sr=0",
                             name, b, o_m_valid, o_m_data, o_m_last, o_s_ready, e[b], b == NB - 1);
                end
                @(negedge clk);
            end
            dr = 1'b1;
            checks++;
            if (o_m_valid !== 1'b1 || o_m_data !== e[b] || o_m_last !== (b == NB - 1)) begin
                errors++;
                $display("FAIL %s beat%0d: v=%b d=%h l=%b, need v=1 d=%h l=%b",
                         name, b, o_m_valid, o_m_data, o_m_last, e[b], b == NB - 1);
            end
            @(negedge clk);
        end
        dr = 1'b0;
        checks++;
        if (o_m_valid !== 1'b0 || o_s_ready !== 1'b1 || o_frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: m_valid=%b s_ready=%b fv=%b, need 0 1 0",
                     name, o_m_valid, o_s_ready, o_frame_valid);
        end
        fcs[sel]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fcs[0] = 0;
        fcs[1] = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_ready !== 1'b1 || frame_valid !== 1'b0 || m_valid !== 1'b0 ||
            m_data !== 64'h0 || m_last !== 1'b0 || frame_data !== 128'h0) begin
            errors++;
            $display("FAIL reset: sr=%b fv=%b mv=%b md=%h ml=%b fd=%h, need 1 0 0 0 0 0",
                     s_ready, frame_valid, m_valid, m_data, m_last, frame_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int k = 0; k < 8; k++) smp[k] = 16'(k + 1);
        send_samples(8, 0);
        check_frame("basic_frame", 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        expect_latency("basic_latency", 3);
        recv_beats("basic", 0, 64'h24, 64'h0004_0003_0002_0001);
    endtask

    task automatic test_stall();
        checks++;
        if (frame_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_retain: fd=%h fv=%b", frame_data, frame_valid);
        end
        send_samples(8, 0);
        check_frame("stall_frame", f_frame());
        expect_latency("stall_latency", 3);
        recv_beats("stall", 5, f_sum(), {smp[3], smp[2], smp[1], smp[0]});
    endtask

    task automatic test_toggle();
        for (int k = 0; k < 8; k++) smp[k] = 16'hFFFF;
        send_samples(8, 1);
        check_frame("toggle_frame", {8{16'hFFFF}});
        expect_latency("toggle_latency", 3);
        recv_beats("toggle", 1, 64'h7FFF8, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) smp[k] = 16'(20 + k);
        send_samples(5, 0);
        checks++;
        if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL partial: fv=%b sr=%b, need 0 1", frame_valid, s_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        fcs[0] = 0;
        fcs[1] = 0;
        checks++;
        if (frame_data !== 128'h0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: fd=%h sr=%b mv=%b, need 0 1 0", frame_data, s_ready, m_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) smp[k] = 16'(10 + k);
        send_samples(8, 0);
        check_frame("reset_frame", 128'h0011_0010_000F_000E_000D_000C_000B_000A);
        expect_latency("reset_latency", 3);
        recv_beats("reset", 0, 64'h6C, 64'h000D_000C_000B_000A);
    endtask

    task automatic test_settle0();
        sel = 1;
        for (int k = 0; k < 8; k++) smp[k] = 16'(16'h0100 + k);
        send_samples(8, 0);
        check_frame("s0_frame", f_frame());
        expect_latency("s0_latency", 1);
        recv_beats("s0", 2, 64'h81C, 64'h0103_0102_0101_0100);
        sel = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) smp[k] = 16'(16'h1000 * (f + 1) + k);
            send_samples(8, 0);
            check_frame("b2b_frame", f_frame());
            expect_latency("b2b_latency", 3);
            recv_beats("b2b", f, f_sum(), {smp[3], smp[2], smp[1], smp[0]});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_mid_reset();
        test_settle0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
